// File: rtl/adc_avg_filter_pkg.sv
// Shared constants, accumulator sizing and FSM encoding for the ADC
// moving-average conditioner and its downstream consumers.
package adc_avg_filter_pkg;

    localparam int DW             = 12;
    localparam int ADC_FULL_SCALE = 4095;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int acc_w(input int dw, input int log2n);
        return dw + log2n;
    endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// N-entry sample ring: one write port at wp, combinational read of the
// same slot so the outgoing sample is seen before it is overwritten.
module avg_ring_buf
#(
    parameter int DW     = 12,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LOG2_N-1:0] wp,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);
    import adc_avg_filter_pkg::*;

    localparam int N = 2 ** LOG2_N;

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wp] = wdata;
        end
    end

    // Contents are never read before being written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[wp];

endmodule

// File: rtl/adc_avg_filter.sv
// Moving average of the last 2**LOG2_N ADC samples with optional
// decimation; drives TR's x/data_valid with a one-cycle pulse.
module adc_avg_filter
#(
    parameter int DW     = 12,
    parameter int LOG2_N = 3,
    parameter int DECIM  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic          enable,
    output logic [DW-1:0] x,
    output logic          data_valid,
    output logic          filt_ready
);
    import adc_avg_filter_pkg::*;

    localparam int                AW       = acc_w(DW, LOG2_N);
    localparam int                N        = 2 ** LOG2_N;
    localparam logic [LOG2_N-1:0] LAST     = LOG2_N'(N - 1);
    localparam logic [LOG2_N-1:0] ONE      = LOG2_N'(1);
    localparam logic [7:0]        DEC_LAST = 8'(DECIM - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d, acc_sum;
    logic [LOG2_N-1:0] wp_q, wp_d;
    logic [LOG2_N-1:0] fill_cnt_q, fill_cnt_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic [DW-1:0]     x_q, x_d;
    logic              data_valid_q, data_valid_d;
    logic              filt_ready_q, filt_ready_d;
    logic              ring_we;
    logic [DW-1:0]     old_sample;

    avg_ring_buf #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk   (clk),
        .we    (ring_we && !rst),
        .wp    (wp_q),
        .wdata (adc_data),
        .rdata (old_sample)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_sum      = acc_q;
        wp_d         = wp_q;
        fill_cnt_d   = fill_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        x_d          = x_q;
        data_valid_d = 1'b0;
        filt_ready_d = filt_ready_q;
        ring_we      = 1'b0;

        if (!enable) begin
            // Flush: window restarts, last x stays on the bus.
            state_d      = FILL;
            acc_d        = '0;
            wp_d         = '0;
            fill_cnt_d   = '0;
            dec_cnt_d    = '0;
            filt_ready_d = 1'b0;
        end else if (adc_valid) begin
            ring_we = 1'b1;
            wp_d    = wp_q + ONE;
            unique case (state_q)
                FILL: begin
                    acc_sum    = acc_q + AW'(adc_data);
                    fill_cnt_d = fill_cnt_q + ONE;
                    if (fill_cnt_q == LAST) begin
                        state_d      = RUN;
                        filt_ready_d = 1'b1;
                        dec_cnt_d    = '0;
                        x_d          = DW'(acc_sum >> LOG2_N);
                        data_valid_d = 1'b1;
                    end
                end
                RUN: begin
                    acc_sum = acc_q + AW'(adc_data) - AW'(old_sample);
                    if (dec_cnt_q == DEC_LAST) begin
                        dec_cnt_d    = '0;
                        x_d          = DW'(acc_sum >> LOG2_N);
                        data_valid_d = 1'b1;
                    end else begin
                        dec_cnt_d = dec_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            acc_q        <= '0;
            wp_q         <= '0;
            fill_cnt_q   <= '0;
            dec_cnt_q    <= '0;
            x_q          <= '0;
            data_valid_q <= 1'b0;
            filt_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            wp_q         <= wp_d;
            fill_cnt_q   <= fill_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            x_q          <= x_d;
            data_valid_q <= data_valid_d;
            filt_ready_q <= filt_ready_d;
        end
    end

    assign x          = x_q;
    assign data_valid = data_valid_q;
    assign filt_ready = filt_ready_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter: a DECIM=1 and a DECIM=4 instance
// share stimulus and are checked against a queue-based window model.
module tb_adc_avg_filter;
    import adc_avg_filter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic        enable = 1'b0;
    logic [11:0] x1, x4;
    logic        dv1, dv4, fr1, fr4;

    int n_cmp = 0;
    int n_err = 0;

    int win[$];
    int q1[$];
    int q4[$];
    int hold1 = 0;
    int hold4 = 0;
    int d4 = 0;
    bit full = 1'b0;

    always #10 clk = ~clk;

    adc_avg_filter #(.DW(12), .LOG2_N(3), .DECIM(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .enable     (enable),
        .x          (x1),
        .data_valid (dv1),
        .filt_ready (fr1)
    );

    adc_avg_filter #(.DW(12), .LOG2_N(3), .DECIM(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .enable     (enable),
        .x          (x4),
        .data_valid (dv4),
        .filt_ready (fr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic v,
                         input logic [11:0] d);
        int s;
        int avg;
        if (r || !e) begin
            win.delete();
            full = 1'b0;
            d4 = 0;
            if (r) begin
                hold1 = 0;
                hold4 = 0;
            end
        end else if (v) begin
            win.push_back(int'(d));
            if (win.size() > 8) void'(win.pop_front());
            if (win.size() == 8) begin
                s = 0;
                foreach (win[i]) s += win[i];
                avg = s / 8;
                q1.push_back(avg);
                if (!full) begin
                    q4.push_back(avg);
                    d4 = 0;
                end else if (d4 == 3) begin
                    q4.push_back(avg);
                    d4 = 0;
                end else begin
                    d4++;
                end
                full = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        int e;
        chk("dv1", 32'(dv1), 32'(q1.size() != 0));
        if (q1.size() != 0) begin
            e = q1.pop_front();
            hold1 = e;
            if (dv1) chk("x1", 32'(x1), 32'(e));
        end else begin
            chk("hold1", 32'(x1), 32'(hold1));
        end
        chk("fr1", 32'(fr1), 32'(full));
        chk("dv4", 32'(dv4), 32'(q4.size() != 0));
        if (q4.size() != 0) begin
            e = q4.pop_front();
            hold4 = e;
            if (dv4) chk("x4", 32'(x4), 32'(e));
        end else begin
            chk("hold4", 32'(x4), 32'(hold4));
        end
        chk("fr4", 32'(fr4), 32'(full));
    endtask

    task automatic cyc(input logic r, input logic e, input logic v,
                       input logic [11:0] d);
        @(negedge clk);
        rst = r;
        enable = e;
        adc_valid = v;
        adc_data = d;
        @(posedge clk);
        model(r, e, v, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) cyc(1'b0, e, 1'b0, 12'd0);
    endtask

    initial begin
        // Reset, even with valid and enable asserted
        cyc(1'b1, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b1, 1'b1, 12'd999);
        idle(2, 1'b1);

        // T1: constant 100 every 5 clk
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 12'd100);
            idle(4, 1'b1);
        end

        // T2: step to 180
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 12'd180);
            idle(1, 1'b1);
        end

        // T3: flush with coincident valids, then refill
        cyc(1'b0, 1'b0, 1'b1, 12'd4000);
        idle(100, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 12'd3000);
        idle(99, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 12'(200 + i));
            idle(1, 1'b1);
        end

        // T4: back-to-back full scale, then zero
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 1'b1, 1'b1, 12'(ADC_FULL_SCALE));
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b1, 12'd0);
        idle(3, 1'b1);

        // T5: constant 50 from fresh reset, decimation on dut4
        cyc(1'b1, 1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, 1'b1, 12'd50);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 12'd50);
            idle(2, 1'b1);
        end

        // T6: reset mid-RUN beats valid/enable, then refill
        cyc(1'b1, 1'b1, 1'b1, 12'd3333);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b1, 12'd77);
        idle(2, 1'b1);

        // Mixed traffic
        for (int i = 0; i < 80; i++)
            cyc(1'b0, 1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
